// File: rtl/servo_position_ctrl_pkg.sv
// Shared widths, defaults, debouncer state encoding and the saturating
// target-step helper for the servo position controller.
package servo_pkg;

   localparam int DUTY_W       = 8;
   localparam int DUTY_MIN_DEF = 0;
   localparam int DUTY_MAX_DEF = 255;
   localparam int STEP_DEF     = 10;

   typedef enum logic [1:0] {
      DB_IDLE         = 2'd0,
      DB_PRESS_WAIT   = 2'd1,
      DB_HELD         = 2'd2,
      DB_RELEASE_WAIT = 2'd3
   } db_state_t;

   // Up/down by step with clamping; simultaneous or absent presses keep cur.
   function automatic logic [DUTY_W-1:0] step_target(
      input logic [DUTY_W-1:0] cur,
      input logic              up,
      input logic              dn,
      input logic [DUTY_W:0]   step,
      input logic [DUTY_W:0]   lo,
      input logic [DUTY_W:0]   hi
   );
      logic [DUTY_W:0]        sum;
      logic signed [DUTY_W:0] diff;
      logic [DUTY_W-1:0]      res;
      sum  = {1'b0, cur} + step;
      diff = $signed({1'b0, cur}) - $signed(step);
      if (up && !dn) begin
         res = (sum > hi) ? hi[DUTY_W-1:0] : sum[DUTY_W-1:0];
      end else if (dn && !up) begin
         res = (diff < $signed(lo)) ? lo[DUTY_W-1:0] : diff[DUTY_W-1:0];
      end else begin
         res = cur;
      end
      return res;
   endfunction

endpackage

// File: rtl/servo_position_ctrl_if.sv
// Button inputs and duty outputs of the servo position controller.
interface servo_position_ctrl_if;
   import servo_pkg::*;

   logic              btn_up;
   logic              btn_down;
   logic [DUTY_W-1:0] duty;
   logic              duty_upd;
   logic              at_target;

   modport master (output btn_up, btn_down, input duty, duty_upd, at_target);
   modport slave  (input btn_up, btn_down, output duty, duty_upd, at_target);

endinterface

// File: rtl/servo_position_ctrl_debounce.sv
// Active-low button synchronizer and debouncer; pulses once per accepted press.
module btn_debounce
   import servo_pkg::*;
#(
   parameter int DEBOUNCE_TICKS = 270000
) (
   input  logic i_clk,
   input  logic i_rst,
   input  logic i_btn_n,
   output logic o_press
);

   localparam int               CNT_W    = (DEBOUNCE_TICKS > 1) ? $clog2(DEBOUNCE_TICKS) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_TICKS - 1);

   logic [1:0]       r_sync;
   db_state_t        r_state;
   db_state_t        w_state_nxt;
   logic [CNT_W-1:0] r_cnt;
   logic [CNT_W-1:0] w_cnt_nxt;
   logic             w_level;
   logic             w_press;

   assign w_level = ~r_sync[1];
   assign o_press = w_press;

   // Two-flop synchronizer; resets to the released (high) level.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_sync <= 2'b11;
      end else begin
         r_sync <= {r_sync[0], i_btn_n};
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_state <= DB_IDLE;
         r_cnt   <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = '0;
      w_press     = 1'b0;
      case (r_state)
         DB_IDLE: begin
            if (w_level) w_state_nxt = DB_PRESS_WAIT;
            else         w_state_nxt = DB_IDLE;
         end
         DB_PRESS_WAIT: begin
            if (!w_level) begin
               w_state_nxt = DB_IDLE;
            end else if (r_cnt == CNT_LAST) begin
               w_state_nxt = DB_HELD;
               w_press     = 1'b1;
            end else begin
               w_cnt_nxt = r_cnt + 1'b1;
            end
         end
         DB_HELD: begin
            if (!w_level) w_state_nxt = DB_RELEASE_WAIT;
            else          w_state_nxt = DB_HELD;
         end
         DB_RELEASE_WAIT: begin
            if (w_level) begin
               w_state_nxt = DB_HELD;
            end else if (r_cnt == CNT_LAST) begin
               w_state_nxt = DB_IDLE;
            end else begin
               w_cnt_nxt = r_cnt + 1'b1;
            end
         end
         default: begin
            w_state_nxt = DB_IDLE;
         end
      endcase
   end

endmodule

// File: rtl/servo_position_ctrl.sv
// Servo position controller: debounced up/down buttons set a target and the
// PWM compare value ramps toward it one LSB per ramp period.
module servo_position_ctrl
   import servo_pkg::*;
#(
   parameter int CLK_HZ         = 27000000,
   parameter int DEBOUNCE_TICKS = 270000,
   parameter int RAMP_TICKS     = 27000,
   parameter int STEP           = STEP_DEF,
   parameter int DUTY_MIN       = DUTY_MIN_DEF,
   parameter int DUTY_MAX       = DUTY_MAX_DEF,
   parameter int DUTY_INIT      = 0
) (
   input  logic                  i_clk,
   input  logic                  i_rst,
   servo_position_ctrl_if.slave  io_bus
);

   localparam int                RAMP_W    = (RAMP_TICKS > 1) ? $clog2(RAMP_TICKS) : 1;
   localparam logic [RAMP_W-1:0] RAMP_LAST = RAMP_W'(RAMP_TICKS - 1);
   localparam int                DW1       = DUTY_W + 1;
   localparam logic [DUTY_W-1:0] INIT_V    = DUTY_W'(DUTY_INIT);
   localparam logic [DUTY_W:0]   STEP_V    = DW1'(STEP);
   localparam logic [DUTY_W:0]   MIN_V     = DW1'(DUTY_MIN);
   localparam logic [DUTY_W:0]   MAX_V     = DW1'(DUTY_MAX);

   if (CLK_HZ <= 0 || RAMP_TICKS < 1 || DEBOUNCE_TICKS < 1) begin : g_param_check
      $error("servo_position_ctrl: clock, ramp and debounce parameters must be positive");
   end

   logic              w_press_up;
   logic              w_press_dn;
   logic              w_wrap;
   logic [RAMP_W-1:0] r_ramp_cnt;
   logic [DUTY_W-1:0] r_target;
   logic [DUTY_W-1:0] r_duty;
   logic              r_duty_upd;

   btn_debounce #(.DEBOUNCE_TICKS(DEBOUNCE_TICKS)) u_db_up (
      .i_clk   (i_clk),
      .i_rst   (i_rst),
      .i_btn_n (io_bus.btn_up),
      .o_press (w_press_up)
   );

   btn_debounce #(.DEBOUNCE_TICKS(DEBOUNCE_TICKS)) u_db_dn (
      .i_clk   (i_clk),
      .i_rst   (i_rst),
      .i_btn_n (io_bus.btn_down),
      .o_press (w_press_dn)
   );

   assign w_wrap = (r_ramp_cnt == RAMP_LAST);

   // Free-running ramp counter; target changes never restart it.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_ramp_cnt <= '0;
      end else if (w_wrap) begin
         r_ramp_cnt <= '0;
      end else begin
         r_ramp_cnt <= r_ramp_cnt + 1'b1;
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_target <= INIT_V;
      end else begin
         r_target <= step_target(r_target, w_press_up, w_press_dn, STEP_V, MIN_V, MAX_V);
      end
   end

   // duty_upd is registered alongside duty so it flags the new value.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_duty     <= INIT_V;
         r_duty_upd <= 1'b0;
      end else if (w_wrap && (r_duty != r_target)) begin
         r_duty     <= (r_duty < r_target) ? (r_duty + 1'b1) : (r_duty - 1'b1);
         r_duty_upd <= 1'b1;
      end else begin
         r_duty_upd <= 1'b0;
      end
   end

   assign io_bus.duty      = r_duty;
   assign io_bus.duty_upd  = r_duty_upd;
   assign io_bus.at_target = (r_duty == r_target);

endmodule

// File: tb/tb_servo_position_ctrl.sv
// Self-checking bench: directed scenarios plus randomized button traffic
// against a target/saturation reference model.
module tb_servo_position_ctrl;
   import servo_pkg::*;

   localparam int DB     = 4;
   localparam int RT     = 2;
   localparam int ST     = 10;
   localparam int SETTLE = RT * 256 + 40;

   logic clk = 1'b0;
   logic rst = 1'b1;

   servo_position_ctrl_if bus();

   servo_position_ctrl #(
      .CLK_HZ(27000000), .DEBOUNCE_TICKS(DB), .RAMP_TICKS(RT), .STEP(ST),
      .DUTY_MIN(0), .DUTY_MAX(255), .DUTY_INIT(0)
   ) dut (
      .i_clk  (clk),
      .i_rst  (rst),
      .io_bus (bus.slave)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;
   int model_tgt = 0;

   // Monitor state: every duty change must be a +/-1 step flagged by duty_upd,
   // and update pulses must stay on the fixed ramp grid.
   int         cyc = 0;
   int         upd_cnt = 0;
   int         mon_bad = 0;
   int         gap_bad = 0;
   int         last_upd = 0;
   bit         have_last = 1'b0;
   logic       mon_rst_edge = 1'b1;
   logic [7:0] prev_duty = 8'd0;

   always @(posedge clk) begin
      mon_rst_edge <= rst;
      cyc          <= cyc + 1;
   end

   always @(negedge clk) begin
      if (mon_rst_edge) begin
         have_last <= 1'b0;
      end else if (bus.duty_upd === 1'b1) begin
         if ((int'(bus.duty) - int'(prev_duty) != 1) && (int'(prev_duty) - int'(bus.duty) != 1))
            mon_bad <= mon_bad + 1;
         if (have_last && (((cyc - last_upd) % RT) != 0))
            gap_bad <= gap_bad + 1;
         upd_cnt   <= upd_cnt + 1;
         last_upd  <= cyc;
         have_last <= 1'b1;
      end else if (bus.duty !== prev_duty || bus.duty_upd !== 1'b0) begin
         mon_bad <= mon_bad + 1;
      end
      prev_duty <= bus.duty;
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic cycles(input int n);
      for (int i = 0; i < n; i++) step();
   endtask

   task automatic do_reset();
      rst = 1'b1;
      bus.btn_up = 1'b1;
      bus.btn_down = 1'b1;
      cycles(3);
      rst = 1'b0;
      model_tgt = 0;
   endtask

   // Reference rule: clamp to [0,255]; both buttons together do nothing.
   function automatic int model_press(input int tgt, input bit up, input bit dn);
      int t;
      t = tgt;
      if (up && !dn) t = (tgt + ST > 255) ? 255 : tgt + ST;
      if (dn && !up) t = (tgt - ST < 0) ? 0 : tgt - ST;
      return t;
   endfunction

   task automatic press(input bit up, input bit dn, input int low_len, input int high_len);
      if (up) bus.btn_up = 1'b0;
      if (dn) bus.btn_down = 1'b0;
      cycles(low_len);
      bus.btn_up = 1'b1;
      bus.btn_down = 1'b1;
      cycles(high_len);
   endtask

   task automatic test_reset();
      rst = 1'b1;
      bus.btn_up = 1'b1;
      bus.btn_down = 1'b1;
      cycles(2);
      checks++; if (bus.duty !== 8'd0) begin errors++; $display("FAIL reset_duty: got %0d expected 0", bus.duty); end
      checks++; if (bus.duty_upd !== 1'b0) begin errors++; $display("FAIL reset_upd: got %b expected 0", bus.duty_upd); end
      checks++; if (bus.at_target !== 1'b1) begin errors++; $display("FAIL reset_at_target: got %b expected 1", bus.at_target); end
      rst = 1'b0;
   endtask

   task automatic test_idle();
      int u0;
      u0 = upd_cnt;
      cycles(50);
      checks++; if (bus.duty !== 8'd0) begin errors++; $display("FAIL idle_duty: got %0d expected 0", bus.duty); end
      checks++; if (bus.at_target !== 1'b1) begin errors++; $display("FAIL idle_at_target: got %b expected 1", bus.at_target); end
      checks++; if (upd_cnt - u0 != 0) begin errors++; $display("FAIL idle_upd: got %0d pulses expected 0", upd_cnt - u0); end
   endtask

   task automatic test_single_press();
      int ups[$];
      int bad_gap;
      do_reset();
      bad_gap = 0;
      bus.btn_up = 1'b0;
      for (int i = 0; i < 120; i++) begin
         if (i == 10) bus.btn_up = 1'b1;
         step();
         if (bus.duty_upd === 1'b1) begin
            checks++;
            if (bus.duty !== 8'(ups.size() + 1)) begin
               errors++; $display("FAIL press_ramp_value: got %0d expected %0d", bus.duty, ups.size() + 1);
            end
            if (ups.size() > 0 && i - ups[ups.size()-1] != RT) bad_gap++;
            ups.push_back(i);
         end
      end
      model_tgt = model_press(0, 1'b1, 1'b0);
      checks++; if (ups.size() != 10) begin errors++; $display("FAIL press_upd_count: got %0d expected 10", ups.size()); end
      checks++; if (bad_gap != 0) begin errors++; $display("FAIL press_ramp_spacing: got %0d bad gaps expected 0", bad_gap); end
      checks++; if (bus.duty !== 8'(model_tgt)) begin errors++; $display("FAIL press_duty: got %0d expected %0d", bus.duty, model_tgt); end
      checks++; if (bus.at_target !== 1'b1) begin errors++; $display("FAIL press_at_target: got %b expected 1", bus.at_target); end
   endtask

   task automatic test_glitch();
      int u0;
      do_reset();
      u0 = upd_cnt;
      press(1'b1, 1'b0, 3, 8);
      cycles(40);
      checks++; if (bus.duty !== 8'd0) begin errors++; $display("FAIL glitch_duty: got %0d expected 0", bus.duty); end
      checks++; if (upd_cnt - u0 != 0) begin errors++; $display("FAIL glitch_upd: got %0d pulses expected 0", upd_cnt - u0); end
      checks++; if (bus.at_target !== 1'b1) begin errors++; $display("FAIL glitch_at_target: got %b expected 1", bus.at_target); end
   endtask

   task automatic test_saturation();
      int u0;
      do_reset();
      for (int k = 0; k < 26; k++) begin
         press(1'b1, 1'b0, 10, 10);
         model_tgt = model_press(model_tgt, 1'b1, 1'b0);
      end
      cycles(SETTLE);
      checks++; if (bus.duty !== 8'd255) begin errors++; $display("FAIL sat_high_duty: got %0d expected 255", bus.duty); end
      checks++; if (bus.at_target !== 1'b1) begin errors++; $display("FAIL sat_high_at_target: got %b expected 1", bus.at_target); end
      do_reset();
      u0 = upd_cnt;
      press(1'b0, 1'b1, 10, 10);
      cycles(40);
      checks++; if (bus.duty !== 8'd0) begin errors++; $display("FAIL sat_low_duty: got %0d expected 0", bus.duty); end
      checks++; if (upd_cnt - u0 != 0) begin errors++; $display("FAIL sat_low_upd: got %0d pulses expected 0", upd_cnt - u0); end
   endtask

   task automatic test_both_same_cycle();
      int u0;
      do_reset();
      for (int k = 0; k < 10; k++) begin
         press(1'b1, 1'b0, 10, 10);
         model_tgt = model_press(model_tgt, 1'b1, 1'b0);
      end
      cycles(SETTLE);
      checks++; if (bus.duty !== 8'(model_tgt)) begin errors++; $display("FAIL both_setup_duty: got %0d expected %0d", bus.duty, model_tgt); end
      u0 = upd_cnt;
      press(1'b1, 1'b1, 10, 10);
      cycles(40);
      checks++; if (bus.duty !== 8'd100) begin errors++; $display("FAIL both_duty: got %0d expected 100", bus.duty); end
      checks++; if (upd_cnt - u0 != 0) begin errors++; $display("FAIL both_upd: got %0d pulses expected 0", upd_cnt - u0); end
      checks++; if (bus.at_target !== 1'b1) begin errors++; $display("FAIL both_at_target: got %b expected 1", bus.at_target); end
   endtask

   task automatic test_redirect();
      int  u0;
      int  g0;
      bit  hit;
      do_reset();
      u0 = upd_cnt;
      g0 = gap_bad;
      hit = 1'b0;
      bus.btn_up = 1'b0;
      for (int i = 0; i < 200 && !hit; i++) begin
         if (i == 6) bus.btn_up = 1'b1;
         step();
         if (bus.duty === 8'd4) hit = 1'b1;
      end
      bus.btn_up = 1'b1;
      checks++; if (!hit) begin errors++; $display("FAIL redirect_reach4: got timeout expected duty 4"); end
      press(1'b1, 1'b0, 10, 10);
      model_tgt = model_press(model_press(0, 1'b1, 1'b0), 1'b1, 1'b0);
      cycles(SETTLE);
      checks++; if (bus.duty !== 8'(model_tgt)) begin errors++; $display("FAIL redirect_duty: got %0d expected %0d", bus.duty, model_tgt); end
      checks++; if (upd_cnt - u0 != model_tgt) begin errors++; $display("FAIL redirect_upd_count: got %0d expected %0d", upd_cnt - u0, model_tgt); end
      checks++; if (gap_bad - g0 != 0) begin errors++; $display("FAIL redirect_ramp_grid: got %0d off-grid pulses expected 0", gap_bad - g0); end
   endtask

   task automatic test_reset_mid_ramp();
      int u0;
      bit hit;
      do_reset();
      hit = 1'b0;
      bus.btn_up = 1'b0;
      for (int i = 0; i < 200 && !hit; i++) begin
         if (i == 10) bus.btn_up = 1'b1;
         step();
         if (bus.duty === 8'd7) hit = 1'b1;
      end
      bus.btn_up = 1'b1;
      checks++; if (!hit) begin errors++; $display("FAIL midramp_reach7: got timeout expected duty 7"); end
      rst = 1'b1;
      step();
      checks++; if (bus.duty !== 8'd0) begin errors++; $display("FAIL midramp_rst_duty: got %0d expected 0", bus.duty); end
      checks++; if (bus.duty_upd !== 1'b0) begin errors++; $display("FAIL midramp_rst_upd: got %b expected 0", bus.duty_upd); end
      checks++; if (bus.at_target !== 1'b1) begin errors++; $display("FAIL midramp_rst_at_target: got %b expected 1", bus.at_target); end
      rst = 1'b0;
      model_tgt = 0;
      u0 = upd_cnt;
      cycles(60);
      checks++; if (bus.duty !== 8'd0 || upd_cnt - u0 != 0) begin errors++; $display("FAIL midramp_abandon: got duty %0d pulses %0d expected 0 and 0", bus.duty, upd_cnt - u0); end
   endtask

   task automatic test_reset_while_held();
      do_reset();
      bus.btn_up = 1'b0;
      cycles(15);
      rst = 1'b1;
      step();
      rst = 1'b0;
      cycles(15);
      bus.btn_up = 1'b1;
      model_tgt = model_press(0, 1'b1, 1'b0);
      cycles(SETTLE);
      checks++; if (bus.duty !== 8'(model_tgt)) begin errors++; $display("FAIL held_rst_duty: got %0d expected %0d", bus.duty, model_tgt); end
   endtask

   // Low runs are either clearly short (< DB samples) or clearly long (>= 2*DB).
   task automatic test_random();
      bit up;
      int low_len;
      int high_len;
      do_reset();
      for (int r = 0; r < 3; r++) begin
         for (int k = 0; k < 15; k++) begin
            up = ($urandom_range(0, 2) != 0);
            high_len = 2 * DB + $urandom_range(0, 4);
            if ($urandom_range(0, 3) == 0) begin
               low_len = $urandom_range(1, DB - 1);
            end else begin
               low_len = 2 * DB + $urandom_range(0, 4);
               model_tgt = model_press(model_tgt, up, !up);
            end
            press(up, !up, low_len, high_len);
         end
         cycles(SETTLE);
         checks++; if (bus.duty !== 8'(model_tgt)) begin errors++; $display("FAIL random_duty: got %0d expected %0d", bus.duty, model_tgt); end
         checks++; if (bus.at_target !== 1'b1) begin errors++; $display("FAIL random_at_target: got %b expected 1", bus.at_target); end
      end
   endtask

   task automatic test_monitor();
      checks++; if (mon_bad != 0) begin errors++; $display("FAIL monitor_step: got %0d bad duty changes expected 0", mon_bad); end
      checks++; if (gap_bad != 0) begin errors++; $display("FAIL monitor_grid: got %0d off-grid pulses expected 0", gap_bad); end
   endtask

   initial begin
      bus.btn_up = 1'b1;
      bus.btn_down = 1'b1;
      test_reset();
      test_idle();
      test_single_press();
      test_glitch();
      test_saturation();
      test_both_same_cycle();
      test_redirect();
      test_reset_mid_ramp();
      test_reset_while_held();
      test_random();
      test_monitor();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/servo_position_ctrl.md
SERVO_POSITION_CTRL -- requirements
Module: servo_position_ctrl

Interface
REQ-001 Parameter CLK_HZ, default 27000000; board clock frequency, documentation only.
REQ-002 Parameter DEBOUNCE_TICKS, default 270000; stable cycles required to accept a button level (10 ms).
REQ-003 Parameter RAMP_TICKS, default 27000; cycles per 1-LSB duty move (1 ms).
REQ-004 Parameter STEP, default 10; target change per accepted press.
REQ-005 Parameters DUTY_MIN, default 0; DUTY_MAX, default 255; DUTY_INIT, default 0; duty bounds and reset value.
REQ-006 clk  input  1  single system clock; all logic on its rising edge.
REQ-007 rst  input  1  reset, synchronous, active-high.
REQ-008 btn_up  input  1  raw board button, active-low, asynchronous to clk.
REQ-009 btn_down  input  1  raw board button, active-low, asynchronous to clk.
REQ-010 duty  output  8  compare value for the downstream PWM stage; registered.
REQ-011 duty_upd  output  1  one-cycle pulse in the cycle duty takes a new value.
REQ-012 at_target  output  1  high when duty equals the internal target.

Function
REQ-013 Each button SHALL pass through a 2-flop synchronizer, then be inverted to active-high.
REQ-014 The debouncer SHALL use states IDLE, PRESS_WAIT, HELD, RELEASE_WAIT: IDLE->PRESS_WAIT on sync=1; PRESS_WAIT->HELD after DEBOUNCE_TICKS consecutive 1s, else ->IDLE on any 0; HELD->RELEASE_WAIT on sync=0; RELEASE_WAIT->IDLE after DEBOUNCE_TICKS consecutive 0s, else ->HELD on any 1.
REQ-015 The debouncer SHALL emit a one-cycle press pulse on the PRESS_WAIT->HELD transition only; holding a button SHALL NOT auto-repeat.
REQ-016 Press pulse on up only: target <= min(target+STEP, DUTY_MAX), computed 9-bit, no wrap.
REQ-017 Press pulse on down only: target <= max(target-STEP, DUTY_MIN), computed signed 9-bit, no wrap.
REQ-018 Press pulses from both buttons in the same cycle SHALL leave target unchanged.
REQ-019 A free-running ramp counter SHALL count 0..RAMP_TICKS-1 and wrap; at wrap, duty moves 1 LSB toward target if duty != target.
REQ-020 duty_upd SHALL be 1 exactly in the cycle following a ramp move, i.e. aligned with the new duty value; 0 otherwise.
REQ-021 A target change mid-ramp SHALL redirect the ramp from the current duty without restart of the ramp counter.
REQ-022 Latency: an accepted press changes target in the same cycle as the press pulse; duty begins moving at the next ramp wrap.
REQ-023 at_target SHALL be combinational compare of registered duty and target.

Reset
REQ-024 On rst=1 at a clk edge: duty=DUTY_INIT, target=DUTY_INIT, duty_upd=0, at_target=1, ramp counter=0, debouncers IDLE with counters 0, synchronizers cleared to released.
REQ-025 Reset asserted mid-press or mid-ramp SHALL abandon the operation; a button still held after reset release SHALL be re-debounced and produce one press.

Structure
REQ-026 Shared package servo_pkg SHALL hold DUTY_W=8, default DUTY_MIN/MAX/STEP and the debouncer state encoding.
REQ-027 One sub-module btn_debounce (synchronizer + REQ-014 FSM + counter), instantiated twice.
REQ-028 Output duty SHALL connect directly to the PWM stage compare input; no further handshake.

Verification (DEBOUNCE_TICKS=4, RAMP_TICKS=2, STEP=10)
REQ-029 Reset then idle 50 cycles -> duty=0, at_target=1, no duty_upd pulse.
REQ-030 btn_up low 10 cycles -> one press; target=10; duty steps 1..10 every 2 cycles, 10 duty_upd pulses, at_target=1 after.
REQ-031 btn_up glitch low 3 cycles -> no press, target stays 0.
REQ-032 26 up presses from 0 -> target saturates at 255, never wraps; 1 down press at 0 -> target stays 0.
REQ-033 Both buttons pressed same cycle from target=100 -> target stays 100; up press while ramping 0->10 at duty=4 -> ramp continues to 20.
REQ-034 rst pulsed while duty=7 ramping to 10 -> next cycle duty=0, target=0, duty_upd=0.
